// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory arbiter.
//   arb_state_t       : arbiter FSM states
//   owner_t           : which cache side owns / last owned the memory port
//   WORDS_PER_BLOCK   : 16-bit words per cache block fill
//   BLOCK_OFFSET_BITS : byte-offset bits inside one block (8 words x 2 bytes)
package mem_arb_pkg;

    localparam int WORDS_PER_BLOCK   = 8;
    localparam int BLOCK_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_fill_seq.sv
// Block-fill sequencer: counts issued read commands and returned read words
// for the fill currently in progress.
//   clk, rst     : clock, asynchronous active-high reset
//   active       : a fill state is current; counters are cleared otherwise
//   rvalid       : memory read data valid
//   issue_active : a read command must be issued this cycle
//   issue_idx    : word index of the command issued this cycle
//   recv_idx     : word index of the data returned this cycle
//   last_word    : the final word of the block is being returned this cycle
module mem_fill_seq #(
    parameter int WORDS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       active,
    input  logic       rvalid,
    output logic       issue_active,
    output logic [2:0] issue_idx,
    output logic [2:0] recv_idx,
    output logic       last_word
);

    // One extra bit so issue_cnt can reach WORDS and stop issuing.
    localparam int CW = $clog2(WORDS) + 1;

    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] recv_cnt;

    assign issue_active = active && (issue_cnt < CW'(WORDS));
    assign issue_idx    = 3'(issue_cnt);
    assign recv_idx     = 3'(recv_cnt);
    assign last_word    = active && rvalid && (recv_cnt == CW'(WORDS - 1));

    // Clearing on the last word leaves both counters at zero for the
    // IDLE cycle that always follows, so the next fill starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else if (!active || last_word) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            if (issue_active) begin
                issue_cnt <= issue_cnt + CW'(1);
            end
            if (rvalid) begin
                recv_cnt <= recv_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one pipelined memory port between an instruction cache
// (block fills) and a data cache (block fills or single-word write-through).
//   clk, rst                      : clock, asynchronous active-high reset
//   i_req, i_addr                 : I-side fill request (held until i_done)
//   d_req, d_wr, d_addr, d_wdata  : D-side request; d_wr=1 single-word write
//   i_fill_valid/data/idx         : returned fill words to the I-side
//   d_fill_valid/data/idx         : returned fill words to the D-side
//   i_done, d_done                : one-cycle completion pulses
//   mem_enable, mem_wr            : memory command strobes
//   mem_addr, mem_wdata           : memory command address / write data
//   mem_rdata, mem_rvalid         : in-order read return from memory
module mem_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  i_fill_valid,
    output logic [15:0]           i_fill_data,
    output logic [2:0]            i_fill_idx,
    output logic                  d_fill_valid,
    output logic [15:0]           d_fill_data,
    output logic [2:0]            d_fill_idx,
    output logic                  i_done,
    output logic                  d_done,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_rvalid
);

    import mem_arb_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK = ~ADDR_WIDTH'((1 << BLOCK_OFFSET_BITS) - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = ~ADDR_WIDTH'(1);

    arb_state_t            state;
    arb_state_t            state_nxt;
    owner_t                last_grant;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [15:0]           lat_data;

    logic                  fill_active;
    logic                  issue_active;
    logic [2:0]            issue_idx;
    logic [2:0]            recv_idx;
    logic                  last_word;
    logic                  grant_d;

    assign fill_active = (state == I_FILL) || (state == D_FILL);

    // D wins when it is the only requester, or on a tie when I was the
    // side served most recently.
    assign grant_d = d_req && (!i_req || (last_grant == OWN_I));

    mem_fill_seq #(
        .WORDS (WORDS_PER_BLOCK)
    ) u_fill_seq (
        .clk          (clk),
        .rst          (rst),
        .active       (fill_active),
        .rvalid       (mem_rvalid),
        .issue_active (issue_active),
        .issue_idx    (issue_idx),
        .recv_idx     (recv_idx),
        .last_word    (last_word)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = d_wr ? D_WRITE : D_FILL;
                end else if (i_req) begin
                    state_nxt = I_FILL;
                end
            end
            I_FILL, D_FILL: begin
                if (last_word) begin
                    state_nxt = IDLE;
                end
            end
            D_WRITE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and fairness flop, captured at grant / completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= OWN_I;
            lat_addr   <= '0;
            lat_data   <= '0;
        end else begin
            if (state == IDLE) begin
                if (grant_d) begin
                    lat_addr <= d_addr & (d_wr ? WORD_MASK : BLOCK_MASK);
                    lat_data <= d_wdata;
                end else if (i_req) begin
                    lat_addr <= i_addr & BLOCK_MASK;
                end
            end
            if (last_word) begin
                last_grant <= (state == I_FILL) ? OWN_I : OWN_D;
            end else if (state == D_WRITE) begin
                last_grant <= OWN_D;
            end
        end
    end

    // Output logic: everything is zero outside the owning state, and
    // returned data is gated so idle outputs stay at zero.
    always_comb begin
        i_fill_valid = 1'b0;
        i_fill_data  = '0;
        i_fill_idx   = '0;
        d_fill_valid = 1'b0;
        d_fill_data  = '0;
        d_fill_idx   = '0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state)
            I_FILL, D_FILL: begin
                mem_enable = issue_active;
                if (issue_active) begin
                    mem_addr = lat_addr | ADDR_WIDTH'({issue_idx, 1'b0});
                end
                if (state == I_FILL) begin
                    i_fill_valid = mem_rvalid;
                    i_fill_data  = mem_rvalid ? mem_rdata : 16'h0000;
                    i_fill_idx   = mem_rvalid ? recv_idx : 3'd0;
                    i_done       = last_word;
                end else begin
                    d_fill_valid = mem_rvalid;
                    d_fill_data  = mem_rvalid ? mem_rdata : 16'h0000;
                    d_fill_idx   = mem_rvalid ? recv_idx : 3'd0;
                    d_done       = last_word;
                end
            end
            D_WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = lat_addr;
                mem_wdata  = lat_data;
                d_done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        i_fill_valid;
    logic [15:0] i_fill_data;
    logic [2:0]  i_fill_idx;
    logic        d_fill_valid;
    logic [15:0] d_fill_data;
    logic [2:0]  d_fill_idx;
    logic        i_done;
    logic        d_done;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        inj_rvalid;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    typedef struct {
        logic        side;   // 0 = I, 1 = D
        logic [2:0]  idx;
        logic [15:0] data;
    } fexp_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } cexp_t;

    fexp_t fq[$];
    cexp_t cq[$];

    always #5 clk = ~clk;

    mem_arbiter #(
        .WORDS_PER_BLOCK (8),
        .ADDR_WIDTH      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .d_req        (d_req),
        .d_wr         (d_wr),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .i_fill_valid (i_fill_valid),
        .i_fill_data  (i_fill_data),
        .i_fill_idx   (i_fill_idx),
        .d_fill_valid (d_fill_valid),
        .d_fill_data  (d_fill_data),
        .d_fill_idx   (d_fill_idx),
        .i_done       (i_done),
        .d_done       (d_done),
        .mem_enable   (mem_enable),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid)
    );

    logic [75:0] all_out;
    assign all_out = {i_fill_valid, i_fill_data, i_fill_idx,
                      d_fill_valid, d_fill_data, d_fill_idx,
                      i_done, d_done, mem_enable, mem_wr, mem_addr, mem_wdata};

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Pipelined memory model, read latency of 3 cycles, not reset by rst.
    logic [2:0]  pv = 3'b000;
    logic [15:0] pa0 = 16'h0;
    logic [15:0] pa1 = 16'h0;
    logic [15:0] pa2 = 16'h0;
    always @(posedge clk) begin
        pv  <= {pv[1:0], mem_enable & ~mem_wr};
        pa0 <= mem_addr;
        pa1 <= pa0;
        pa2 <= pa1;
    end
    assign mem_rvalid = pv[2] | inj_rvalid;
    assign mem_rdata  = pv[2] ? mem_f(pa2) : (inj_rvalid ? 16'hDEAD : 16'h0000);

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_fill(input logic side, input logic [15:0] addr);
        logic [15:0] base;
        logic [15:0] a;
        fexp_t fe;
        cexp_t ce;
        base = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            a        = base + 16'(2 * k);
            ce.wr    = 1'b0;
            ce.addr  = a;
            ce.wdata = 16'h0000;
            cq.push_back(ce);
            fe.side  = side;
            fe.idx   = 3'(k);
            fe.data  = mem_f(a);
            fq.push_back(fe);
        end
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input logic side, output int n);
        n = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (side ? d_done : i_done) begin
                n = c;
                return;
            end
        end
        total++;
        failed++;
        $error("FAIL done_timeout: side %0d observed no done within 60 cycles, expected a done pulse", side);
    endtask

    task automatic do_reset();
        drv();
        rst = 1'b1;
        #1;
        chk("reset_outputs", 80'(all_out), 80'(0));
        repeat (2) @(negedge clk);
        drv();
        rst = 1'b0;
    endtask

    // Scoreboard: every fill word and every memory command is popped in order.
    always @(negedge clk) begin
        fexp_t fe;
        cexp_t ce;
        if (i_fill_valid || d_fill_valid) begin
            if (fq.size() == 0) begin
                total++;
                failed++;
                $error("FAIL fill_unexpected: observed i_valid=%0b d_valid=%0b, expected no fill word",
                       i_fill_valid, d_fill_valid);
            end else begin
                fe = fq.pop_front();
                chk("fill_word",
                    80'({i_fill_valid, d_fill_valid,
                         (i_fill_valid ? i_fill_idx : d_fill_idx),
                         (i_fill_valid ? i_fill_data : d_fill_data)}),
                    80'({~fe.side, fe.side, fe.idx, fe.data}));
            end
        end
        if (mem_enable) begin
            if (cq.size() == 0) begin
                total++;
                failed++;
                $error("FAIL cmd_unexpected: observed wr=%0b addr=%0h, expected no command", mem_wr, mem_addr);
            end else begin
                ce = cq.pop_front();
                chk("mem_cmd",
                    80'({mem_wr, mem_addr, (mem_wr ? mem_wdata : 16'h0000), d_done}),
                    80'({ce.wr, ce.addr, ce.wdata, ce.wr}));
            end
        end
        if (i_done) begin
            chk("i_done_align", 80'({d_done, i_fill_valid, i_fill_idx}), 80'({1'b0, 1'b1, 3'd7}));
        end
        if (d_done && !mem_wr) begin
            chk("d_done_align", 80'({i_done, d_fill_valid, d_fill_idx}), 80'({1'b0, 1'b1, 3'd7}));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  found;
        cexp_t ce;
        rst        = 1'b0;
        i_req      = 1'b0;
        i_addr     = 16'h0;
        d_req      = 1'b0;
        d_wr       = 1'b0;
        d_addr     = 16'h0;
        d_wdata    = 16'h0;
        inj_rvalid = 1'b0;
        #1 rst = 1'b1;
        #1 chk("reset_state", 80'(all_out), 80'(0));
        repeat (2) @(negedge clk);
        chk("reset_hold_state", 80'(all_out), 80'(0));
        drv();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_quiet", 80'(all_out), 80'(0));

        // I-side block fill from an unaligned miss address
        drv();
        i_req  = 1'b1;
        i_addr = 16'h1236;
        push_fill(1'b0, 16'h1236);
        wait_done(1'b0, n);
        chk("i_fill_latency", 80'(n), 80'(12));
        drv();
        i_req = 1'b0;

        // D-side single-word write-through
        drv();
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 16'h4003;
        d_wdata = 16'hBEEF;
        ce.wr = 1'b1; ce.addr = 16'h4002; ce.wdata = 16'hBEEF;
        cq.push_back(ce);
        wait_done(1'b1, n);
        chk("write_latency", 80'(n), 80'(2));
        drv();
        d_req = 1'b0;
        d_wr  = 1'b0;

        // Tie from reset: D first, then I, then D again (D re-requests at once)
        do_reset();
        drv();
        i_req  = 1'b1;
        i_addr = 16'h2000;
        d_req  = 1'b1;
        d_addr = 16'h2000;
        push_fill(1'b1, 16'h2000);
        push_fill(1'b0, 16'h2000);
        push_fill(1'b1, 16'h2010);
        wait_done(1'b1, n);
        chk("tie_d_first_latency", 80'(n), 80'(12));
        drv();
        d_addr = 16'h2010;
        wait_done(1'b0, n);
        drv();
        i_req = 1'b0;
        wait_done(1'b1, n);
        drv();
        d_req = 1'b0;

        // D request arriving in the middle of an I fill waits for IDLE
        drv();
        i_req  = 1'b1;
        i_addr = 16'h7774;
        push_fill(1'b0, 16'h7774);
        repeat (4) @(negedge clk);
        drv();
        d_req  = 1'b1;
        d_addr = 16'h501A;
        push_fill(1'b1, 16'h501A);
        wait_done(1'b0, n);
        drv();
        i_req = 1'b0;
        @(negedge clk);
        chk("idle_gap_no_cmd", 80'(mem_enable), 80'(0));
        @(negedge clk);
        chk("d_fill_first_cmd", 80'({mem_enable, mem_wr, mem_addr}), 80'({1'b1, 1'b0, 16'h5010}));
        wait_done(1'b1, n);
        drv();
        d_req = 1'b0;

        // Stray mem_rvalid while idle is ignored; next fill starts at word 0
        repeat (5) @(negedge clk);
        drv();
        inj_rvalid = 1'b1;
        @(negedge clk);
        chk("idle_rvalid_ignored", 80'({i_fill_valid, d_fill_valid, i_done, d_done}), 80'(0));
        drv();
        inj_rvalid = 1'b0;
        drv();
        d_req  = 1'b1;
        d_addr = 16'h6008;
        push_fill(1'b1, 16'h6008);
        wait_done(1'b1, n);
        chk("d_fill_latency", 80'(n), 80'(12));
        drv();
        d_req = 1'b0;

        // Reset after the third returned word abandons the fill
        drv();
        i_req  = 1'b1;
        i_addr = 16'h3000;
        push_fill(1'b0, 16'h3000);
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (i_fill_valid && (i_fill_idx == 3'd2)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            total++;
            failed++;
            $error("FAIL third_word_timeout: observed no third fill word, expected one within 40 cycles");
        end
        #1;
        rst   = 1'b1;
        i_req = 1'b0;
        fq.delete();
        cq.delete();
        #1;
        chk("reset_mid_fill", 80'(all_out), 80'(0));
        repeat (2) begin
            @(negedge clk);
            chk("reset_mid_fill_hold", 80'(all_out), 80'(0));
        end
        drv();
        rst = 1'b0;
        repeat (6) @(negedge clk);
        drv();
        i_req  = 1'b1;
        i_addr = 16'h3000;
        push_fill(1'b0, 16'h3000);
        wait_done(1'b0, n);
        chk("fresh_fill_latency", 80'(n), 80'(12));
        drv();
        i_req = 1'b0;

        repeat (4) @(negedge clk);
        chk("fill_queue_drained", 80'(fq.size()), 80'(0));
        chk("cmd_queue_drained", 80'(cq.size()), 80'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
